// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM state encoding and measurement constants.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StMeasure,
        StCalc,
        StLocked
    } ab_state_e;

    localparam int unsigned SYNC_EDGES = 4;
    localparam int unsigned OVS_SHIFT  = 7;   // log2(16x oversampling * 8 bit times)
    localparam int unsigned ROUND      = 64;

endpackage

// File: rtl/rx_edge_det.sv
// rx falling-edge detector: 2-flop synchroniser plus one delay flop; all flops idle high.
module rx_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic fall
);

    logic sync1_q, sync2_q, dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign fall = dly_q & ~sync2_q;

endmodule

// File: rtl/autobaud_ctrl.sv
// Autobaud controller: measures a 0x55 sync character (or takes a software divisor) and sequences
// the baud generator divisor, enable and clear. Define AUTOBAUD_CHECK_EN for per-interval checks.
module autobaud_ctrl
    import uart_pkg::*;
#(
    parameter  int unsigned DIV_W = 16,
    localparam int unsigned CNT_W = DIV_W + 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic             start,
    input  logic             cfg_wr,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [DIV_W-1:0] div_o,
    output logic             b_en,
    output logic             b_clr,
    output logic             busy,
    output logic             locked,
    output logic             err
);

    ab_state_e        state_q;
    logic [CNT_W-1:0] cnt_q, c_q, cnt_inc;
    logic [2:0]       edges_q;
    logic             fall, viol, q_bad;
    logic [CNT_W:0]   sum;
    logic [DIV_W:0]   q;

    rx_edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .fall  (fall)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign sum     = {1'b0, c_q} + (CNT_W + 1)'(ROUND);
    assign q       = (DIV_W + 1)'(sum >> OVS_SHIFT);
    assign q_bad   = (q == '0) || (q > {1'b1, {DIV_W{1'b0}}});

`ifdef AUTOBAUD_CHECK_EN
    logic [CNT_W-1:0] i0_q, mark_q, ik, dev;

    always_comb begin
        ik   = cnt_inc - mark_q;
        dev  = (ik > i0_q) ? ik - i0_q : i0_q - ik;
        viol = (edges_q != 3'd0) && (dev > (i0_q >> 3));
    end

    // mark_q holds the count at the previous fall, so ik is the latest interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i0_q   <= '0;
            mark_q <= '0;
        end else if (state_q == StArm) begin
            mark_q <= '0;
        end else if (state_q == StMeasure && fall) begin
            if (edges_q == 3'd0) i0_q <= cnt_inc;
            mark_q <= cnt_inc;
        end
    end
`else
    assign viol = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            c_q     <= '0;
            edges_q <= '0;
            div_o   <= '0;
            b_en    <= 1'b0;
            b_clr   <= 1'b0;
            busy    <= 1'b0;
            locked  <= 1'b0;
            err     <= 1'b0;
        end else begin
            b_clr <= 1'b0;
            if (cfg_wr) begin
                // Software load wins over everything, including a same-cycle start.
                div_o   <= cfg_div;
                b_clr   <= 1'b1;
                b_en    <= 1'b0;
                err     <= 1'b0;
                busy    <= 1'b0;
                locked  <= 1'b1;
                state_q <= StLocked;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            state_q <= StArm;
                        end
                    end
                    StArm: begin
                        if (fall) begin
                            cnt_q   <= '0;
                            edges_q <= '0;
                            state_q <= StMeasure;
                        end
                    end
                    StMeasure: begin
                        cnt_q <= cnt_inc;
                        if (cnt_q == '1 || (fall && viol)) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else if (fall) begin
                            if (edges_q == 3'(SYNC_EDGES - 1)) begin
                                c_q     <= cnt_inc;
                                state_q <= StCalc;
                            end else begin
                                edges_q <= edges_q + 3'd1;
                            end
                        end
                    end
                    StCalc: begin
                        busy <= 1'b0;
                        if (q_bad) begin
                            err     <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            div_o   <= DIV_W'(q - (DIV_W + 1)'(1));
                            b_clr   <= 1'b1;
                            locked  <= 1'b1;
                            state_q <= StLocked;
                        end
                    end
                    StLocked: begin
                        if (start) begin
                            b_en    <= 1'b0;
                            locked  <= 1'b0;
                            busy    <= 1'b1;
                            err     <= 1'b0;
                            state_q <= StArm;
                        end else begin
                            b_en <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_autobaud_ctrl.sv
// Self-checking bench for autobaud_ctrl: frame-level divisor model plus per-cycle output checks.
module tb_autobaud_ctrl;

    localparam int unsigned DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx = 1'b1;
    logic             start = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [DIV_W-1:0] div_o;
    logic             b_en, b_clr, busy, locked, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state shared with the per-cycle compare process.
    logic [DIV_W-1:0] exp_div = '0;
    logic [DIV_W-1:0] exp_next = '0;
    bit               expect_change = 1'b0;
    int               clr_cnt = 0;
    bit               prev_clr = 1'b0;

    typedef struct packed {
        logic             err;
        logic [DIV_W-1:0] div;
    } res_t;

    autobaud_ctrl #(.DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .start   (start),
        .cfg_wr  (cfg_wr),
        .cfg_div (cfg_div),
        .div_o   (div_o),
        .b_en    (b_en),
        .b_clr   (b_clr),
        .busy    (busy),
        .locked  (locked),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic frame_bit(input int i);
        logic [7:0] pat;
        pat = 8'h55;
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return pat[i-1];
    endfunction

    // Outcome of one 0x55 frame from fall times and the divisor rules.
    function automatic res_t predict(input int bit_t, input int sidx, input int extra);
        res_t r;
        int   falls[$];
        int   t, c, q;
        logic lvl, b;
        t = 0;
        lvl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b = frame_bit(i);
            if (lvl && !b) falls.push_back(t);
            lvl = b;
            t += bit_t + ((i == sidx) ? extra : 0);
        end
        r.err = 1'b0;
        r.div = '0;
`ifdef AUTOBAUD_CHECK_EN
        for (int k = 2; k <= 4; k++) begin
            int i0, ik, dev;
            i0 = falls[1] - falls[0];
            ik = falls[k] - falls[k-1];
            dev = (ik > i0) ? ik - i0 : i0 - ik;
            if (dev > i0 / 8) r.err = 1'b1;
        end
`endif
        c = falls[4] - falls[0];
        q = (c + 64) / 128;
        if (!r.err) begin
            if (q == 0 || q > (1 << DIV_W)) r.err = 1'b1;
            else r.div = DIV_W'(q - 1);
        end
        return r;
    endfunction

    task automatic send_frame(input int bit_t, input int sidx, input int extra);
        for (int i = 0; i < 10; i++) begin
            rx = frame_bit(i);
            tick(bit_t + ((i == sidx) ? extra : 0));
        end
        rx = 1'b1;
    endtask

    task automatic measure(input string name, input int bit_t, input int sidx, input int extra,
                           input logic lit_err, input int lit_div);
        res_t r;
        int   clr0;
        r = predict(bit_t, sidx, extra);
        check({name, "_model_err"}, r.err, lit_err);
        if (!lit_err) check({name, "_model_div"}, r.div, lit_div);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check({name, "_armed_busy"}, busy, 1);
        check({name, "_armed_b_en"}, b_en, 0);
        check({name, "_armed_err_clr"}, err, 0);
        if (!r.err) begin
            exp_next = r.div;
            expect_change = 1'b1;
        end
        clr0 = clr_cnt;
        send_frame(bit_t, sidx, extra);
        tick(8);
        check({name, "_clr_pulses"}, clr_cnt - clr0, r.err ? 0 : 1);
        check({name, "_err"}, err, r.err);
        check({name, "_locked"}, locked, !r.err);
        check({name, "_b_en"}, b_en, !r.err);
        check({name, "_busy"}, busy, 0);
        if (!r.err) check({name, "_div"}, div_o, lit_div);
    endtask

    // Per-cycle compare: div_o may only move to the predicted value on a b_clr cycle.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (b_clr) begin
                check("clr_expected", expect_change, 1);
                check("clr_div", div_o, exp_next);
                check("clr_b_en_low", b_en, 0);
                check("clr_locked", locked, 1);
                exp_div = exp_next;
                expect_change = 1'b0;
                clr_cnt++;
            end else begin
                check("div_stable", div_o, exp_div);
            end
            if (prev_clr && locked) check("b_en_after_clr", b_en, 1);
            check("b_en_only_locked", b_en & ~locked, 0);
            check("busy_locked_excl", busy & locked, 0);
            prev_clr = b_clr;
        end
    end

    initial begin : main
        int clr0;
        tick(2);
        check("rst_div", div_o, 0);
        check("rst_b_en", b_en, 0);
        check("rst_b_clr", b_clr, 0);
        check("rst_busy", busy, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick(3);

        measure("bt160", 160, -1, 0, 1'b0, 9);
        measure("bt868", 868, -1, 0, 1'b0, 53);

        // cfg_wr in the middle of a measurement aborts it.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        rx = 1'b0; tick(160);
        rx = 1'b1; tick(160);
        rx = 1'b0; tick(160);
        check("abort_busy_before", busy, 1);
        exp_next = 8'hA5;
        expect_change = 1'b1;
        clr0 = clr_cnt;
        cfg_div = 8'hA5;
        cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        check("abort_locked", locked, 1);
        check("abort_busy", busy, 0);
        check("abort_b_clr", b_clr, 1);
        for (int i = 0; i < 6; i++) begin
            rx = ~rx;
            tick(160);
        end
        rx = 1'b1;
        tick(10);
        check("abort_clr_pulses", clr_cnt - clr0, 1);
        check("abort_div", div_o, 8'hA5);
        check("abort_b_en", b_en, 1);

        // cfg_wr and start together: cfg_wr wins.
        exp_next = 8'h3C;
        expect_change = 1'b1;
        cfg_div = 8'h3C;
        cfg_wr = 1'b1;
        start = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
        start = 1'b0;
        check("both_busy", busy, 0);
        check("both_locked", locked, 1);
        tick(3);
        check("both_b_en", b_en, 1);
        check("both_div", div_o, 8'h3C);

        measure("bt4", 4, -1, 0, 1'b1, 0);

        // Timeout: one fall then silence until the counter saturates.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("to_err_clr", err, 0);
        rx = 1'b0; tick(5);
        rx = 1'b1; tick(32000);
        check("to_not_early_busy", busy, 1);
        check("to_not_early_err", err, 0);
        tick(1000);
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_locked", locked, 0);
        check("to_div", div_o, 8'h3C);

        measure("stretch40", 160, 3, 40, 1'b0, 9);
`ifdef AUTOBAUD_CHECK_EN
        measure("stretch64", 160, 3, 64, 1'b1, 0);
`else
        measure("stretch64", 160, 3, 64, 1'b0, 10);
`endif

        // Reset in the middle of a measurement.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        rx = 1'b0; tick(100);
        rx = 1'b1; tick(50);
        expect_change = 1'b0;
        exp_div = '0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_div", div_o, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_b_en", b_en, 0);
        check("mid_rst_err", err, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_busy", busy, 0);

        measure("bt160_again", 160, -1, 0, 1'b0, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
